vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_axis_counter.sv | 39 +++
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing defaults and coordinate type for all renderers.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sync windows are half-open: [START, END).
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  function automatic logic in_range(coord_t v, int unsigned lo, int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping scan counter for one axis; resets to MAX so the first increment lands on 0.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned MAX = 799
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  input  logic   inc,
  output coord_t cnt,
  output coord_t next_cnt,
  output logic   wrap
);

  localparam coord_t MaxVal = coord_t'(MAX);

  coord_t cnt_q;

  assign cnt  = cnt_q;
  assign wrap = inc && (cnt_q == MaxVal);

  always_comb begin
    next_cnt = cnt_q;
    if (wrap) begin
      next_cnt = '0;
    end else if (inc) begin
      next_cnt = cnt_q + coord_t'(1);
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= MaxVal;
    end else begin
      cnt_q <= next_cnt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator; all outputs registered from the next counter value.
// Optional VGA_SYNC_DELAY_EN adds one register stage on hs/vs only.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT     = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK      = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT     = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK      = vga_pkg::V_BACK,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  output coord_t                 DrawX,
  output coord_t                 DrawY,
  output logic                   blank,
  output logic                   hs,
  output logic                   vs,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int unsigned HTotal     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HSyncStart = H_VISIBLE + H_FRONT;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
  localparam int unsigned VSyncStart = V_VISIBLE + V_FRONT;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;

  coord_t hc, hc_next, vc, vc_next;
  logic   h_wrap, v_wrap;

  vga_axis_counter #(
    .MAX(HTotal - 1)
  ) u_hcnt (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .inc     (1'b1),
    .cnt     (hc),
    .next_cnt(hc_next),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .MAX(VTotal - 1)
  ) u_vcnt (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .inc     (h_wrap),
    .cnt     (vc),
    .next_cnt(vc_next),
    .wrap    (v_wrap)
  );

  logic                   blank_d, hs_d, vs_d;
  logic                   blank_q, hs_q, vs_q, line_start_q, frame_start_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;

  // h_wrap/v_wrap mean the next position is column 0 / pixel (0,0).
  always_comb begin
    blank_d = (32'(hc_next) < H_VISIBLE) && (32'(vc_next) < V_VISIBLE);
    hs_d    = !in_range(hc_next, HSyncStart, HSyncEnd);
    vs_d    = !in_range(vc_next, VSyncStart, VSyncEnd);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '1;
    end else begin
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
      if (v_wrap) begin
        frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
      end
    end
  end

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

`ifdef VGA_SYNC_DELAY_EN
  logic hs_dly_q, vs_dly_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_dly_q <= 1'b1;
      vs_dly_q <= 1'b1;
    end else begin
      hs_dly_q <= hs_q;
      vs_dly_q <= vs_q;
    end
  end

  assign hs = hs_dly_q;
  assign vs = vs_dly_q;
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: full-size timing instance plus a tiny-timing instance (4-bit frame_count).
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int   t;
    int   run;
    obs_t b;
    obs_t s;
  } item_t;

  logic        vga_clk;
  logic        reset_n;
  logic [9:0]  bx, by, sx, sy;
  logic        bblank, bhs, bvs, bls, bfs;
  logic        sblank, shs, svs, sls, sfs;
  logic [15:0] bfc;
  logic [3:0]  sfc;

  int    checks = 0;
  int    errors = 0;
  int    t_model = -1;
  int    run_id = 0;
  item_t exp_q[$];
  event  ev_async;

  int big_hs_low = 0, big_blank = 0, big_ls = 0;
  int small_fs = 0, small_vs_low = 0, small_blank = 0, small_wrap = 0;

  vga_timing_gen u_big (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (bx),
    .DrawY      (by),
    .blank      (bblank),
    .hs         (bhs),
    .vs         (bvs),
    .line_start (bls),
    .frame_start(bfs),
    .frame_count(bfc)
  );

  vga_timing_gen #(
    .H_VISIBLE  (8),
    .H_FRONT    (2),
    .H_SYNC     (3),
    .H_BACK     (2),
    .V_VISIBLE  (4),
    .V_FRONT    (1),
    .V_SYNC     (2),
    .V_BACK     (1),
    .FRAME_CNT_W(4)
  ) u_small (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (sx),
    .DrawY      (sy),
    .blank      (sblank),
    .hs         (shs),
    .vs         (svs),
    .line_start (sls),
    .frame_start(sfs),
    .frame_count(sfc)
  );

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  // t = cycles presented since reset release (t=0 is the first (0,0)); t<0 means in reset.
  function automatic obs_t model(int t, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb, int fcw);
    obs_t e;
    int ht, vt, x, y, st, px, py;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (t < 0) begin
      e.x = 10'(ht - 1);
      e.y = 10'(vt - 1);
      e.blank = 1'b0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.ls = 1'b0;
      e.fs = 1'b0;
      e.fc = 16'((1 << fcw) - 1);
      return e;
    end
    x = t % ht;
    y = (t / ht) % vt;
    e.x = 10'(x);
    e.y = 10'(y);
    e.blank = (x < hv) && (y < vv);
    e.ls = (x == 0);
    e.fs = (x == 0) && (y == 0);
    e.fc = 16'((t / (ht * vt)) % (1 << fcw));
`ifdef VGA_SYNC_DELAY_EN
    st = t - 1;
`else
    st = t;
`endif
    if (st < 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
    end else begin
      px = st % ht;
      py = (st / ht) % vt;
      e.hs = !((px >= hv + hf) && (px < hv + hf + hsw));
      e.vs = !((py >= vv + vf) && (py < vv + vf + vsw));
    end
    return e;
  endfunction

  function automatic item_t make_item(int t, int run);
    item_t it;
    it.t = t;
    it.run = run;
    it.b = model(t, 640, 16, 96, 48, 480, 10, 2, 33, 16);
    it.s = model(t, 8, 2, 3, 2, 4, 1, 2, 1, 4);
    return it;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic cmp_obs(input string tag, input int t, input obs_t g, input obs_t e);
    chk($sformatf("%s.DrawX t=%0d", tag, t), int'(g.x), int'(e.x));
    chk($sformatf("%s.DrawY t=%0d", tag, t), int'(g.y), int'(e.y));
    chk($sformatf("%s.blank t=%0d", tag, t), int'(g.blank), int'(e.blank));
    chk($sformatf("%s.hs t=%0d", tag, t), int'(g.hs), int'(e.hs));
    chk($sformatf("%s.vs t=%0d", tag, t), int'(g.vs), int'(e.vs));
    chk($sformatf("%s.line_start t=%0d", tag, t), int'(g.ls), int'(e.ls));
    chk($sformatf("%s.frame_start t=%0d", tag, t), int'(g.fs), int'(e.fs));
    chk($sformatf("%s.frame_count t=%0d", tag, t), int'(g.fc), int'(e.fc));
  endtask

  // Expected-response producer: one item per clock edge.
  initial begin
    forever begin
      @(posedge vga_clk);
      if (!reset_n) t_model = -1;
      else t_model = t_model + 1;
      exp_q.push_back(make_item(t_model, run_id));
    end
  end

  // Monitor: pops one expectation per presented output state.
  initial begin
    item_t it;
    obs_t gb, gs;
    logic [3:0] prev_sfc;
    prev_sfc = 4'd0;
    forever begin
      @(negedge vga_clk or ev_async);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
        it = exp_q.pop_front();
        gb.x = bx; gb.y = by; gb.blank = bblank; gb.hs = bhs; gb.vs = bvs;
        gb.ls = bls; gb.fs = bfs; gb.fc = bfc;
        gs.x = sx; gs.y = sy; gs.blank = sblank; gs.hs = shs; gs.vs = svs;
        gs.ls = sls; gs.fs = sfs; gs.fc = {12'd0, sfc};
        cmp_obs("big", it.t, gb, it.b);
        cmp_obs("small", it.t, gs, it.s);
        if (it.run == 0 && it.t >= 0) begin
          if (it.t < 800 && !bhs) big_hs_low++;
          if (it.t < 800 && bblank) big_blank++;
          if (it.t < 2500 && bls) big_ls++;
          if (it.t < 2500 && sfs) small_fs++;
          if (it.t < 120 && !svs) small_vs_low++;
          if (it.t < 120 && sblank) small_blank++;
          if (it.t > 0 && prev_sfc == 4'd15 && sfc == 4'd0) small_wrap++;
        end
        prev_sfc = sfc;
      end
    end
  end

  initial begin
    int found;
    reset_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    #2 reset_n = 1'b1;
    repeat (2500) @(posedge vga_clk);

    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge vga_clk);
      if (bx == 10'd300) found = 1;
    end
    chk("reach_DrawX_300", found, 1);

    // Mid-line async reset: reset values must appear without a clock edge.
    #2;
    run_id = 1;
    reset_n = 1'b0;
    #1;
    t_model = -1;
    exp_q.push_back(make_item(-1, run_id));
    ->ev_async;
    repeat (5) @(negedge vga_clk);
    #2 reset_n = 1'b1;
    repeat (900) @(posedge vga_clk);
    @(negedge vga_clk);
    #5;

    chk("big hs low cycles in line 0", big_hs_low, 96);
    chk("big blank high cycles in line 0", big_blank, 640);
    chk("big line_start pulses in 2500 cycles", big_ls, 4);
    chk("small frame_start pulses in 2500 cycles", small_fs, 21);
    chk("small vs low cycles in frame 0", small_vs_low, 30);
    chk("small blank high cycles in frame 0", small_blank, 32);
    chk("small frame_count 15->0 wraps", small_wrap, 1);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
